exec_stage_p: RTL and testbench

Parametrised ALU/execute pipeline stage that succeeds the fixed 16-bit execute stage. It sits between the decoder and the memory/writeback stage. It adds valid/ready handshaking with backpressure, and flag updates only when the instruction requests them. It also adds an iterative multi-cycle multiply and a flush input. Operand selection is done upstream; this block evaluates the condition, computes the result, updates flags and registers the outgoing control word.

---
 rtl/exec_stage_p.sv | 227 ++++++++++++++++++++++
 tb/tb_exec_stage_p.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_p.sv
// -----------------------------------------------------------------------------
// exec_stage_p
// Parametrised execute stage between the decoder and memory/writeback.
// Evaluates the condition code against the current flags, computes the ALU
// result (single-cycle ops, or an iterative shift-add multiply), updates the
// {Z, C} flags when asked, and registers the outgoing control word behind a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous kill of the in-flight multiply and output
//   in_valid / in_ready  upstream handshake
//   in_op, in_src_a/b    operation and operands
//   in_cond, in_flag_we  condition code, flag write enable
//   in_dest_pc, in_reg_set, in_reg_dest   write-back target
//   in_mem_rd/wr, in_bank, in_pc, in_imm  pass-through memory/PC fields
//   mem_op_next          combinational "memory op arriving" hint
//   out_valid / out_ready downstream handshake
//   out_*                registered result and control word
//   flags                {Z, C}
//   busy                 multiply in progress
// -----------------------------------------------------------------------------
module exec_stage_p #(
  parameter int  DATA_W  = 16,
  parameter int  BANK_W  = 8,
  parameter int  RDEST_W = 4,
  localparam int ADDR_W  = BANK_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [DATA_W-1:0]  in_src_a,
  input  logic [DATA_W-1:0]  in_src_b,
  input  logic [5:0]         in_cond,
  input  logic               in_flag_we,
  input  logic               in_dest_pc,
  input  logic [1:0]         in_reg_set,
  input  logic [RDEST_W-1:0] in_reg_dest,
  input  logic [1:0]         in_mem_rd,
  input  logic [1:0]         in_mem_wr,
  input  logic [BANK_W-1:0]  in_bank,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_imm,
  output logic               mem_op_next,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_reg_write,
  output logic [RDEST_W-1:0] out_reg_dest,
  output logic               out_set_pc,
  output logic [1:0]         out_mem_rd,
  output logic [1:0]         out_mem_wr,
  output logic [ADDR_W-1:0]  out_mem_addr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_imm,
  output logic [1:0]         flags,
  output logic               busy
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_PA  = 3'd5;
  localparam logic [2:0] OP_PB  = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // Everything except the result that travels with an instruction.
  typedef struct packed {
    logic               set_pc;
    logic [1:0]         reg_write;
    logic [RDEST_W-1:0] reg_dest;
    logic [1:0]         mem_rd;
    logic [1:0]         mem_wr;
    logic [ADDR_W-1:0]  mem_addr;
    logic [ADDR_W-1:0]  pc;
    logic [DATA_W-1:0]  imm;
  } ctl_t;

  logic [0:0]          state;
  logic                z_q, c_q;
  ctl_t                out_ctl_q, mul_ctl_q, ctl_in;
  logic                mul_flag_we_q;
  logic [2*DATA_W-1:0] acc_q, mcand_q, acc_next;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mul_last;

  logic                z_term, c_term, exec_en, accept;
  logic [DATA_W:0]     alu_sum;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  // Condition against the flags as they stand at acceptance.
  assign z_term  = in_cond[4] | (in_cond[3] == z_q);
  assign c_term  = in_cond[1] | (in_cond[0] == c_q);
  assign exec_en = in_cond[5] & (in_cond[2] ? (z_term & c_term) : (z_term | c_term));

  assign in_ready    = (state == ST_IDLE) & (~out_valid | out_ready);
  assign accept      = in_valid & in_ready & ~flush;
  assign mem_op_next = in_valid & (in_mem_rd[0] | in_mem_wr[0]);

  always_comb begin
    ctl_in           = '0;
    ctl_in.set_pc    = exec_en & in_dest_pc;
    ctl_in.reg_write = (exec_en & ~in_dest_pc) ? in_reg_set : 2'b00;
    ctl_in.reg_dest  = in_reg_dest;
    ctl_in.mem_rd    = in_mem_rd;
    ctl_in.mem_wr    = in_mem_wr;
    ctl_in.mem_addr  = {in_bank, (in_mem_wr[0] ? in_src_b : in_src_a)};
    ctl_in.pc        = in_pc;
    ctl_in.imm       = in_imm;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_sum = {1'b0, in_src_a} + {1'b0, in_src_b};
    case (in_op)
      OP_ADD: begin
        alu_res = alu_sum[DATA_W-1:0];
        alu_c   = alu_sum[DATA_W];
      end
      OP_SUB: begin
        alu_res = in_src_a - in_src_b;
        alu_c   = in_src_a < in_src_b;
      end
      OP_AND:  alu_res = in_src_a & in_src_b;
      OP_OR:   alu_res = in_src_a | in_src_b;
      OP_XOR:  alu_res = in_src_a ^ in_src_b;
      OP_PA:   alu_res = in_src_a;
      OP_PB:   alu_res = in_src_b;
      default: alu_res = '0;  // MUL goes through the iterative path
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CNT_W'(DATA_W - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the multiply datapath registers are reset along with the control
  // state; they are few, and a known value keeps simulation free of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      z_q           <= 1'b0;
      c_q           <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_ctl_q     <= '0;
      mul_ctl_q     <= '0;
      mul_flag_we_q <= 1'b0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      cnt_q         <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;

      if (state == ST_MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (mul_last) begin
          state     <= ST_IDLE;
          cnt_q     <= '0;
          out_valid <= 1'b1;
          out_data  <= acc_next[DATA_W-1:0];
          out_ctl_q <= mul_ctl_q;
          if (mul_flag_we_q) begin
            z_q <= (acc_next[DATA_W-1:0] == '0);
            c_q <= |acc_next[2*DATA_W-1:DATA_W];
          end
        end
      end else if (accept) begin
        if (in_op == OP_MUL) begin
          state         <= ST_MUL;
          acc_q         <= '0;
          mcand_q       <= {{DATA_W{1'b0}}, in_src_a};
          mplier_q      <= in_src_b;
          cnt_q         <= '0;
          mul_ctl_q     <= ctl_in;
          mul_flag_we_q <= in_flag_we;
        end else begin
          out_valid <= 1'b1;
          out_data  <= alu_res;
          out_ctl_q <= ctl_in;
          if (in_flag_we) begin
            z_q <= (alu_res == '0);
            c_q <= alu_c;
          end
        end
      end
    end
  end

  assign out_set_pc    = out_ctl_q.set_pc;
  assign out_reg_write = out_ctl_q.reg_write;
  assign out_reg_dest  = out_ctl_q.reg_dest;
  assign out_mem_rd    = out_ctl_q.mem_rd;
  assign out_mem_wr    = out_ctl_q.mem_wr;
  assign out_mem_addr  = out_ctl_q.mem_addr;
  assign out_pc        = out_ctl_q.pc;
  assign out_imm       = out_ctl_q.imm;
  assign flags         = {z_q, c_q};
  assign busy          = (state == ST_MUL);

endmodule

// File: tb/tb_exec_stage_p.sv
// -----------------------------------------------------------------------------
// tb_exec_stage_p
// Directed scenarios followed by randomized traffic for exec_stage_p
// (DATA_W=16, BANK_W=8, RDEST_W=4). Expected results come from a
// transaction-level model: arithmetic on integers and an in-order queue.
// -----------------------------------------------------------------------------
module tb_exec_stage_p;

  localparam int DW = 16;
  localparam int BW = 8;
  localparam int RW = 4;
  localparam int AW = BW + DW;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, PA = 3'd5, PB = 3'd6, MUL = 3'd7;

  logic          clk, rst_n, flush;
  logic          in_valid, in_ready;
  logic [2:0]    in_op;
  logic [DW-1:0] in_src_a, in_src_b;
  logic [5:0]    in_cond;
  logic          in_flag_we, in_dest_pc;
  logic [1:0]    in_reg_set;
  logic [RW-1:0] in_reg_dest;
  logic [1:0]    in_mem_rd, in_mem_wr;
  logic [BW-1:0] in_bank;
  logic [AW-1:0] in_pc;
  logic [DW-1:0] in_imm;
  logic          mem_op_next, out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_reg_write;
  logic [RW-1:0] out_reg_dest;
  logic          out_set_pc;
  logic [1:0]    out_mem_rd, out_mem_wr;
  logic [AW-1:0] out_mem_addr, out_pc;
  logic [DW-1:0] out_imm;
  logic [1:0]    flags;
  logic          busy;

  exec_stage_p #(.DATA_W(DW), .BANK_W(BW), .RDEST_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_cond(in_cond),
    .in_flag_we(in_flag_we), .in_dest_pc(in_dest_pc), .in_reg_set(in_reg_set),
    .in_reg_dest(in_reg_dest), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_bank(in_bank), .in_pc(in_pc), .in_imm(in_imm),
    .mem_op_next(mem_op_next), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_reg_write(out_reg_write), .out_reg_dest(out_reg_dest),
    .out_set_pc(out_set_pc), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_mem_addr(out_mem_addr), .out_pc(out_pc), .out_imm(out_imm),
    .flags(flags), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Reference model: one instruction at a time, in acceptance order.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    flg;
    logic          set_pc;
    logic [1:0]    rw;
    logic [AW-1:0] addr;
    logic [AW-1:0] pc;
  } exp_t;

  bit   m_z, m_c;
  exp_t exp_q[$];

  function automatic exp_t model(input logic [2:0] op, input int unsigned a, input int unsigned b,
                                 input logic [5:0] cond, input bit fwe, input bit dpc,
                                 input logic [1:0] rs, input logic [1:0] mw,
                                 input logic [BW-1:0] bank, input logic [AW-1:0] pc);
    exp_t e;
    bit zt, ct, ex, c;
    longint unsigned full;
    longint unsigned res;
    zt = cond[4] || (cond[3] == m_z);
    ct = cond[1] || (cond[0] == m_c);
    ex = cond[5] && (cond[2] ? (zt && ct) : (zt || ct));
    c  = 0;
    case (op)
      ADD:     begin full = longint'(a) + longint'(b); res = full % 65536; c = (full >= 65536); end
      SUB:     begin res = (65536 + a - b) % 65536; c = (a < b); end
      AND_:    res = a & b;
      OR_:     res = a | b;
      XOR_:    res = a ^ b;
      PA:      res = a;
      PB:      res = b;
      default: begin full = longint'(a) * longint'(b); res = full % 65536; c = (full >= 65536); end
    endcase
    if (fwe) begin
      m_z = (res == 0);
      m_c = c;
    end
    e.data   = DW'(res);
    e.flg    = {m_z, m_c};
    e.set_pc = ex && dpc;
    e.rw     = (ex && !dpc) ? rs : 2'b00;
    e.addr   = {bank, (mw[0] ? DW'(b) : DW'(a))};
    e.pc     = pc;
    return e;
  endfunction

  task automatic set_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [5:0] cond, input logic fwe, input logic dpc,
                        input logic [1:0] rs);
    in_valid = 1'b1; in_op = op; in_src_a = a; in_src_b = b; in_cond = cond;
    in_flag_we = fwe; in_dest_pc = dpc; in_reg_set = rs; in_reg_dest = '0;
    in_mem_rd = '0; in_mem_wr = '0; in_bank = '0; in_pc = '0; in_imm = '0;
  endtask

  // Counts cycles with busy high after a multiply was accepted; also records
  // whether in_ready was ever seen high during that window.
  task automatic mul_wait(output int n, output bit rdy_seen);
    n = 0;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (!busy) break;
      n++;
      if (in_ready) rdy_seen = 1;
    end
  endtask

  int n_busy;
  bit rdy_seen, ov_seen;

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_op(ADD, '0, '0, '0, 1'b0, 1'b0, 2'b00);
    in_valid = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    check("rst_reg_write", out_reg_write, 0);
    check("rst_mem_addr", out_mem_addr, 0);
    rst_n = 1'b1;

    // ---- ADD with carry wrap to zero ----
    @(negedge clk);
    set_op(ADD, 16'hFFFF, 16'h0001, 6'b110010, 1'b1, 1'b0, 2'b11);
    #1 check("add_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("add_valid", out_valid, 1);
    check("add_data", out_data, 16'h0000);
    check("add_flags", flags, 2'b11);
    check("add_reg_write", out_reg_write, 2'b11);

    // ---- SUB borrow, then conditional jumps on C ----
    @(negedge clk);
    set_op(SUB, 16'h0003, 16'h0005, 6'b110010, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    set_op(ADD, 16'h0001, 16'h0001, 6'b110101, 1'b0, 1'b1, 2'b11);
    #1;
    check("sub_data", out_data, 16'hFFFE);
    check("sub_flags", flags, 2'b01);
    @(negedge clk);
    set_op(ADD, 16'h0001, 16'h0001, 6'b110100, 1'b0, 1'b1, 2'b11);
    #1;
    check("jmp_c1_set_pc", out_set_pc, 1);
    check("jmp_c1_reg_write", out_reg_write, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("jmp_c0_set_pc", out_set_pc, 0);
    check("jmp_c0_valid", out_valid, 1);
    check("jmp_c0_flags", flags, 2'b01);

    // ---- MUL 0x100*0x100 then 7*9 ----
    @(negedge clk);
    set_op(MUL, 16'h0100, 16'h0100, 6'b110010, 1'b1, 1'b0, 2'b11);
    #1 check("mul1_in_ready", in_ready, 1);
    mul_wait(n_busy, rdy_seen);
    check("mul1_busy_cycles", n_busy, 16);
    check("mul1_in_ready_low", rdy_seen, 0);
    check("mul1_valid", out_valid, 1);
    check("mul1_data", out_data, 16'h0000);
    check("mul1_flags", flags, 2'b11);
    set_op(MUL, 16'h0007, 16'h0009, 6'b110010, 1'b1, 1'b0, 2'b11);
    mul_wait(n_busy, rdy_seen);
    check("mul2_busy_cycles", n_busy, 16);
    check("mul2_data", out_data, 16'h003F);
    check("mul2_flags", flags, 2'b00);

    // ---- backpressure ----
    @(negedge clk);
    out_ready = 1'b0;
    set_op(AND_, 16'hF0F0, 16'h0FF0, 6'b110010, 1'b0, 1'b0, 2'b01);
    #1 check("bp_first_ready", in_ready, 1);
    @(negedge clk);
    set_op(XOR_, 16'h1234, 16'h00FF, 6'b110010, 1'b0, 1'b0, 2'b01);
    #1;
    check("bp_first_valid", out_valid, 1);
    check("bp_first_data", out_data, 16'h00F0);
    check("bp_blocked", in_ready, 0);
    @(negedge clk);
    #1;
    check("bp_hold_data", out_data, 16'h00F0);
    check("bp_hold_blocked", in_ready, 0);
    out_ready = 1'b1;
    #1 check("bp_ready_up", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_data", out_data, 16'h12CB);
    @(negedge clk);
    #1 check("bp_drained", out_valid, 0);

    // ---- flush mid-multiply ----
    set_op(SUB, 16'h0003, 16'h0005, 6'b110010, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    set_op(MUL, 16'h0007, 16'h0009, 6'b110010, 1'b1, 1'b0, 2'b11);
    #1 check("fl_prior_flags", flags, 2'b01);
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_valid", out_valid, 0);
    check("fl_busy", busy, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_flags", flags, 2'b01);
    ov_seen = 0;
    repeat (20) begin
      @(negedge clk);
      #1 if (out_valid) ov_seen = 1;
    end
    check("fl_no_output", ov_seen, 0);
    check("fl_flags_kept", flags, 2'b01);

    // ---- asynchronous reset with output held, and mid-multiply ----
    out_ready = 1'b0;
    set_op(ADD, 16'hFFFF, 16'h0002, 6'b110010, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ar_held_valid", out_valid, 1);
    check("ar_held_flags", flags, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_reg_write", out_reg_write, 0);
    check("ar_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_op(MUL, 16'h0003, 16'h0005, 6'b110010, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("ar_mul_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_mul_busy_clr", busy, 0);
    check("ar_mul_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- memory address formation ----
    set_op(PA, 16'h3456, 16'h0000, 6'b110010, 1'b0, 1'b0, 2'b00);
    in_bank = 8'h12; in_mem_rd = 2'b11;
    #1 check("mem_rd_next", mem_op_next, 1);
    @(negedge clk);
    set_op(PB, 16'h1111, 16'hABCD, 6'b110010, 1'b0, 1'b0, 2'b00);
    in_bank = 8'h34; in_mem_wr = 2'b01;
    #1;
    check("mem_rd_addr", out_mem_addr, 24'h123456);
    check("mem_rd_field", out_mem_rd, 2'b11);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mem_wr_addr", out_mem_addr, 24'h34ABCD);
    check("mem_wr_field", out_mem_wr, 2'b01);
    check("mem_idle_next", mem_op_next, 0);

    // ---- randomized traffic against the model ----
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_z = 0;
    m_c = 0;
    begin
      int n_total, issued, consumed;
      bit pend;
      exp_t e;
      n_total = 300; issued = 0; consumed = 0; pend = 0;
      for (int cyc = 0; cyc < 20000 && consumed < n_total; cyc++) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 3) != 0);
        if (!pend && issued < n_total && $urandom_range(0, 2) != 0) begin
          in_valid    = 1'b1;
          in_op       = 3'($urandom_range(0, 7));
          in_src_a    = DW'($urandom);
          in_src_b    = ($urandom_range(0, 5) == 0) ? in_src_a : DW'($urandom);
          in_cond     = 6'($urandom);
          in_flag_we  = 1'($urandom);
          in_dest_pc  = ($urandom_range(0, 3) == 0);
          in_reg_set  = 2'($urandom);
          in_reg_dest = RW'($urandom);
          in_mem_rd   = 2'($urandom);
          in_mem_wr   = 2'($urandom);
          in_bank     = BW'($urandom);
          in_pc       = AW'($urandom);
          in_imm      = DW'($urandom);
          pend        = 1;
        end else if (!pend) begin
          in_valid = 1'b0;
        end
        #1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("rnd_unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rnd_data", out_data, e.data);
            check("rnd_flags", flags, e.flg);
            check("rnd_set_pc", out_set_pc, e.set_pc);
            check("rnd_reg_write", out_reg_write, e.rw);
            check("rnd_mem_addr", out_mem_addr, e.addr);
            check("rnd_pc", out_pc, e.pc);
          end
          consumed++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(in_op, in_src_a, in_src_b, in_cond, in_flag_we, in_dest_pc,
                                in_reg_set, in_mem_wr, in_bank, in_pc));
          pend = 0;
          issued++;
        end
      end
      check("rnd_all_consumed", consumed, n_total);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
